// File: rtl/ram_word_arb.sv
// ram_word_arb: two-requester round-robin arbiter that turns 32-bit word
// accesses into four byte beats on a byte-wide RAM port with a registered
// read path. Each word is little-endian: beat b carries byte b.
// Optional feature macro: RAM_WORD_ARB_BE_EN adds per-requester byte
// enables (m0_be / m1_be) that gate ram_we on write beats.
module ram_word_arb (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [9:0]  m0_addr,
  input  logic [31:0] m0_wdata,
`ifdef RAM_WORD_ARB_BE_EN
  input  logic [3:0]  m0_be,
`endif
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [9:0]  m1_addr,
  input  logic [31:0] m1_wdata,
`ifdef RAM_WORD_ARB_BE_EN
  input  logic [3:0]  m1_be,
`endif
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,

  output logic        ram_we,
  output logic [9:0]  ram_waddr,
  output logic [9:0]  ram_raddr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  beat;
  logic        ptr;
  logic        owner;
  logic        we_q;
  logic [7:0]  word_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [23:0] rd_buf;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        any_req;
  logic        sel;
  logic        grant;
  logic        sel_we;
  logic [9:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic        rd_fin;
  logic [31:0] word_done;

  // Word-offset bits of the byte address are ignored by design.
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  // Arbitration: contention resolved by the pointer, a lone requester wins outright.
  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) begin
      sel = ptr;
    end else begin
      sel = m1_req;
    end
    grant = (state == IDLE) && any_req && !rst;
  end

  // Mux the selected requester's transaction fields for capture at grant.
  always_comb begin
    sel_we    = sel ? m1_we    : m0_we;
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;
`ifdef RAM_WORD_ARB_BE_EN
    sel_be    = sel ? m1_be    : m0_be;
`else
    sel_be    = '1;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> XFER on grant, four beats, one FIN cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (grant) state_nxt = XFER;
      XFER: if (beat == 2'd3) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter: cleared in IDLE, advances each XFER cycle, wraps into FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (state == XFER) begin
      beat <= beat + 2'd1;
    end else begin
      beat <= '0;
    end
  end

  // Round-robin pointer and transaction latch, loaded on the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= 1'b0;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (grant) begin
      ptr     <= ~sel;
      owner   <= sel;
      we_q    <= sel_we;
      word_q  <= sel_addr[9:2];
      wdata_q <= sel_wdata;
      be_q    <= sel_be;
    end
  end

  // Read assembly: RAM data lags the address by one cycle, so beat b
  // collects byte b-1 and the FIN cycle supplies byte 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_buf <= '0;
    end else if (state == XFER && !we_q) begin
      unique case (beat)
        2'd1:    rd_buf[7:0]   <= ram_rdata;
        2'd2:    rd_buf[15:8]  <= ram_rdata;
        2'd3:    rd_buf[23:16] <= ram_rdata;
        default: rd_buf        <= rd_buf;
      endcase
    end
  end

  // Per-requester read result, committed when the owner's read finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (rd_fin) begin
      if (owner) begin
        rdata1_q <= word_done;
      end else begin
        rdata0_q <= word_done;
      end
    end
  end

  // Completed read word is forwarded during FIN so rdata is valid with done.
  always_comb begin
    rd_fin    = (state == FIN) && !we_q && !rst;
    word_done = {ram_rdata, rd_buf};
    m0_rdata  = (rd_fin && !owner) ? word_done : rdata0_q;
    m1_rdata  = (rd_fin &&  owner) ? word_done : rdata1_q;
  end

  // Output logic: grants, done pulses and RAM controls, all forced low in reset.
  always_comb begin
    m0_gnt    = grant && !sel;
    m1_gnt    = grant &&  sel;
    m0_done   = (state == FIN) && !rst && !owner;
    m1_done   = (state == FIN) && !rst &&  owner;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_raddr = '0;
    ram_wdata = '0;
    if (state == XFER) begin
      ram_waddr = {word_q, beat};
      ram_raddr = {word_q, beat};
      if (we_q) begin
        ram_we    = be_q[beat] && !rst;
        ram_wdata = wdata_q[{beat, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: doc/ram_word_arb.md
RAM_WORD_ARB -- requirements
Module: ram_word_arb

Interface
REQ-001 Port list SHALL be exactly as below; one clock, reset synchronous active-high; N in {0,1}.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 mN_req  in  1  requester N word-access request; held with mN_we/mN_addr/mN_wdata stable until mN_gnt.
REQ-005 mN_we  in  1  1 = word write, 0 = word read.
REQ-006 mN_addr  in  10  byte address; bits [1:0] ignored (word aligned).
REQ-007 mN_wdata  in  32  write word, little-endian (byte 0 = bits 7:0).
REQ-008 mN_gnt  out  1  one-cycle grant; request captured on this edge.
REQ-009 mN_done  out  1  one-cycle completion pulse, write or read.
REQ-010 mN_rdata  out  32  read word; valid when mN_done=1 for a read, held until next read completes for N.
REQ-011 ram_we  out  1; ram_waddr  out  10; ram_raddr  out  10; ram_wdata  out  8: byte RAM write/read controls.
REQ-012 ram_rdata  in  8  byte RAM read data, registered: valid one cycle after ram_raddr is presented.

Function
REQ-013 FSM states SHALL be IDLE, XFER, FIN; 2-bit beat counter; 1-bit round-robin pointer.
REQ-014 IDLE: if any mN_req, assert mN_gnt combinationally for the selected requester, latch we/addr/wdata/owner, beat=0, go XFER.
REQ-015 Both requests in same IDLE cycle: grant the requester indicated by pointer; pointer then points to the other requester.
REQ-016 Single requester: grant it regardless of pointer; pointer then points to the other requester.
REQ-017 XFER beat b (0..3): ram_waddr = ram_raddr = {addr[9:2], b}.
REQ-018 XFER write: ram_we=1, ram_wdata = wdata[8b+7:8b].
REQ-019 XFER read: ram_we=0; at beats 1..3 capture ram_rdata into byte b-1 of read buffer.
REQ-020 After beat 3, go FIN; FIN read: capture ram_rdata into byte 3, drive mN_rdata from completed buffer.
REQ-021 FIN: assert owner's mN_done for exactly one cycle, go IDLE.
REQ-022 Timing: gnt at cycle T, beats T+1..T+4, done at T+5; next gnt earliest T+6.
REQ-023 Outside XFER: ram_we=0, ram_waddr=ram_raddr=0, ram_wdata=0.
REQ-024 mN_gnt SHALL only be asserted in IDLE; never both gnt in one cycle; at most one transaction outstanding.
REQ-025 Requests asserted while busy are ignored until IDLE; no queuing.
REQ-026 Non-owner mN_rdata SHALL not change during another requester's transaction.

Reset
REQ-027 rst=1 at posedge: state IDLE, beat 0, pointer to m0, all gnt/done/ram_we 0, mN_rdata = 32'h0.
REQ-028 Reset mid-transaction aborts it: no done pulse; bytes already written stay in RAM.
REQ-029 gnt SHALL be 0 during any cycle rst is 1.

Configuration
REQ-030 Macro RAM_WORD_ARB_BE_EN: when defined, adds mN_be  in  4 per requester, latched at grant.
REQ-031 With RAM_WORD_ARB_BE_EN, write beat b drives ram_we = be[b]; beat still consumes its cycle; reads ignore be.
REQ-032 Without RAM_WORD_ARB_BE_EN, mN_be ports absent; all 4 bytes written on every write.

Verification
REQ-033 m0 write addr 0x010 wdata 0xDDCCBBAA -> ram writes 0x010=AA,0x011=BB,0x012=CC,0x013=DD on T+1..T+4; m0_done at T+5.
REQ-034 m1 read addr 0x013 after REQ-033 -> raddr 0x010..0x013; m1_done at T+5 with m1_rdata=0xDDCCBBAA.
REQ-035 m0 and m1 req held continuously from reset -> grants alternate m0,m1,m0,m1, one gnt per 6 cycles.
REQ-036 rst pulsed at beat 2 of m0 write 0x11223344 to 0x020 -> no m0_done; 0x020=44,0x021=33; next grant goes to m0.
REQ-037 RAM_WORD_ARB_BE_EN, m0 write be=4'b0101 data 0xFFFFFFFF to 0x040 -> ram_we only beats 0,2; readback 0x00FF00FF from zeroed RAM.
REQ-038 m1 req asserted during m0 transfer -> no m1_gnt until m0 done; m1_gnt in the IDLE cycle after FIN.
